second_level_merge: RTL and testbench
=====================================

// Module: second_level_merge
// PURPOSE
//  Consumer of the packed pair-sorted bus produced by the first sort level.
//  Loads NUM_WORDS words as sorted runs of RUN_LEN and merges adjacent runs
//  into sorted runs of 2*RUN_LEN, emitting one merged word per clock.
//  Next stage of the merge-sort pipeline; instances chain with doubled RUN_LEN.
// PARAMETERS
//  WORD_W     8  bits per word
//  NUM_WORDS  8  words on the packed bus; must be a multiple of 2*RUN_LEN
//  RUN_LEN    2  length of each sorted input run (2 = pairs from first level)
// PORTS
//  clock     in   1                  system clock, all logic on posedge
//  reset     in   1                  synchronous, active-high
//  start     in   1                  one-cycle request: capture runs_in and merge
//  runs_in   in   NUM_WORDS*WORD_W   packed input; word 0 in MSBs
//  busy      out  1                  high from cycle after accepted start until done
//  done      out  1                  one-cycle pulse: runs_out valid and stable
//  runs_out  out  NUM_WORDS*WORD_W   packed merged runs of 2*RUN_LEN; word 0 in MSBs
//  run_err   out  1                  input run not ascending (MERGE_ORDER_CHECK_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, run_err=0, runs_out=0, internal buffers
//    and pointers cleared. Reset overrides all other inputs in the same cycle.
//  - States: IDLE -> LOAD -> MERGE -> DONE -> IDLE.
//  - IDLE: start=1 latches runs_in into the input buffer, goes to LOAD. start=0 stays.
//  - LOAD: one cycle; busy=1; group index g=0, pointers ia=ib=0, write index k=0.
//  - MERGE: each cycle writes one word to output buffer slot g*2*RUN_LEN+k.
//    A = run 2g, B = run 2g+1 (word indices counted from MSB).
//    ia<RUN_LEN and (ib==RUN_LEN or A[ia]<=B[ib]): take A[ia], ia++;
//    otherwise take B[ib], ib++. Ties take A (stable). Compare is unsigned.
//    After 2*RUN_LEN writes: g++, ia=ib=k=0. After last group -> DONE.
//  - DONE: runs_out <= output buffer; done=1 for exactly this cycle; busy=0;
//    returns to IDLE next cycle. runs_out holds until the next DONE or reset.
//  - Latency: start accepted at cycle 0; LOAD at cycle 1; MERGE cycles
//    2..NUM_WORDS+1; done high at cycle NUM_WORDS+2 (cycle 10 with defaults).
//  - start while not IDLE is ignored; runs_in sampled only at the accepting edge.
//  - Reset mid-MERGE aborts: no done pulse, runs_out cleared to 0.
//  - Pointers are sized for RUN_LEN inclusive; they never wrap past RUN_LEN.
//  - Input words outside ascending order are not repaired; the merge rule above
//    still applies deterministically.
// CONFIGURATION
//  MERGE_ORDER_CHECK_EN defined: during LOAD every input run is checked for
//    ascending order (word[i]<=word[i+1] within the run); any violation sets
//    run_err, held until the next accepted start or reset.
//  MERGE_ORDER_CHECK_EN undefined: no check logic; run_err tied to 0.
// TESTING
//  1 Defaults, runs_in={03,07,01,09,05,05,02,04}, start pulse -> done at cycle 10,
//    runs_out={01,03,07,09,02,04,05,05}, busy high cycles 1-9.
//  2 Exhaustion: runs_in={01,02,08,09,0A,0B,00,01} -> runs_out={01,02,08,09,00,01,0A,0B}.
//  3 Ties/stability: runs_in={05,FF,05,FF,00,00,00,00} -> {05,05,FF,FF,00,00,00,00}.
//  4 start re-pulsed at cycles 3 and 9 with different data -> ignored, single
//    done at cycle 10 with case-1 result; a start at cycle 11 runs normally.
//  5 reset asserted at cycle 5 of a merge -> next cycle busy=0, runs_out=0,
//    no done pulse; fresh start afterwards completes in 10 cycles.
//  6 runs_in={07,03,...} (run 0 descending): with MERGE_ORDER_CHECK_EN run_err=1
//    from cycle 2 until next start; without the macro run_err stays 0.

Source files
------------

// File: rtl/second_level_merge.sv
// Second merge-sort stage: merges adjacent sorted runs of RUN_LEN into runs of 2*RUN_LEN, one word per clock.
// Optional input-run order checking is compiled in with `define MERGE_ORDER_CHECK_EN.
module second_level_merge #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 8,
    parameter int RUN_LEN   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_WORDS*WORD_W-1:0] runs_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_WORDS*WORD_W-1:0] runs_out,
    output logic                        run_err
);
    localparam int NUM_GROUPS = NUM_WORDS / (2 * RUN_LEN);
    localparam int PW = $clog2(RUN_LEN + 1);
    localparam int KW = (2 * RUN_LEN > 1) ? $clog2(2 * RUN_LEN) : 1;
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [PW-1:0] RUN_END = PW'(RUN_LEN);
    localparam logic [KW-1:0] K_LAST  = KW'(2 * RUN_LEN - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MERGE, DONE} state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] in_buf   [NUM_WORDS];
    logic [WORD_W-1:0] out_buf  [NUM_WORDS];
    logic [WORD_W-1:0] out_next [NUM_WORDS];
    logic [WORD_W-1:0] in_words [NUM_WORDS];
    logic [PW-1:0]     ia_reg, ib_reg;
    logic [KW-1:0]     k_reg;
    logic [GW-1:0]     g_reg;
    logic [IW-1:0]     base, a_idx, b_idx, w_idx;
    logic [WORD_W-1:0] a_word, b_word, pick;
    logic              take_a;
    logic [NUM_WORDS*WORD_W-1:0] out_packed;

    // Word 0 sits in the MSBs of both packed buses.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_pack
            assign in_words[gi] = runs_in[(NUM_WORDS-1-gi)*WORD_W +: WORD_W];
            assign out_packed[(NUM_WORDS-1-gi)*WORD_W +: WORD_W] = out_next[gi];
        end
    endgenerate

    // Exhausted-run reads are masked, so an out-of-range b_idx is never used.
    always_comb begin
        base   = IW'(g_reg) * IW'(2 * RUN_LEN);
        a_idx  = base + IW'(ia_reg);
        b_idx  = base + IW'(RUN_LEN) + IW'(ib_reg);
        w_idx  = base + IW'(k_reg);
        a_word = (ia_reg < RUN_END) ? in_buf[a_idx] : '0;
        b_word = (ib_reg < RUN_END) ? in_buf[b_idx] : '0;
        take_a = (ia_reg < RUN_END) && ((ib_reg == RUN_END) || (a_word <= b_word));
        pick   = take_a ? a_word : b_word;
        out_next = out_buf;
        if (state_reg == MERGE) begin
            out_next[w_idx] = pick;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            runs_out  <= '0;
            ia_reg    <= '0;
            ib_reg    <= '0;
            k_reg     <= '0;
            g_reg     <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                in_buf[i]  <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            in_buf[i] <= in_words[i];
                        end
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    ia_reg    <= '0;
                    ib_reg    <= '0;
                    k_reg     <= '0;
                    g_reg     <= '0;
                    state_reg <= MERGE;
                end
                MERGE: begin
                    out_buf[w_idx] <= pick;
                    if (take_a) ia_reg <= ia_reg + 1'b1;
                    else        ib_reg <= ib_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        k_reg  <= '0;
                        ia_reg <= '0;
                        ib_reg <= '0;
                        if (g_reg == G_LAST) begin
                            // out_packed already carries this cycle's final write.
                            runs_out  <= out_packed;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            g_reg <= g_reg + 1'b1;
                        end
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MERGE_ORDER_CHECK_EN
    logic [NUM_WORDS-2:0] pair_bad;
    logic                 run_err_reg;

    // Only neighbours inside the same run are compared; run boundaries are skipped.
    generate
        for (genvar gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_order
            if (((gi + 1) % RUN_LEN) != 0) begin : g_inner
                assign pair_bad[gi] = (in_buf[gi] > in_buf[gi+1]);
            end else begin : g_edge
                assign pair_bad[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            run_err_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            run_err_reg <= 1'b0;
        end else if (state_reg == LOAD && (|pair_bad)) begin
            run_err_reg <= 1'b1;
        end
    end

    assign run_err = run_err_reg;
`else
    assign run_err = 1'b0;
`endif

endmodule

// File: tb/tb_second_level_merge.sv
// Self-checking bench for second_level_merge: table vectors, random runs against a queue-based merge model,
// and hand-written sequences for re-pulsed start and mid-merge reset.
module tb_second_level_merge;
    localparam int W  = 8;
    localparam int NW = 8;
    localparam int RL = 2;

    logic          clock, reset, start;
    logic [NW*W-1:0] runs_in, runs_out;
    logic          busy, done, run_err;

    int n_checks = 0;
    int n_fail   = 0;

    second_level_merge #(.WORD_W(W), .NUM_WORDS(NW), .RUN_LEN(RL)) dut (
        .clock(clock), .reset(reset), .start(start), .runs_in(runs_in),
        .busy(busy), .done(done), .runs_out(runs_out), .run_err(run_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NW*W-1:0] din;
        logic [NW*W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference merge: two queues per group, take from A while A's head <= B's head.
    function automatic logic [NW*W-1:0] merge_model(input logic [NW*W-1:0] v);
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [NW*W-1:0] r;
        int o;
        r = '0;
        o = 0;
        for (int g = 0; g < NW / (2 * RL); g++) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < RL; i++) begin
                qa.push_back(v[(NW-1-(2*g*RL+i))*W +: W]);
                qb.push_back(v[(NW-1-(2*g*RL+RL+i))*W +: W]);
            end
            while (qa.size() > 0 || qb.size() > 0) begin
                if (qa.size() > 0 && (qb.size() == 0 || qa[0] <= qb[0]))
                    r[(NW-1-o)*W +: W] = qa.pop_front();
                else
                    r[(NW-1-o)*W +: W] = qb.pop_front();
                o++;
            end
        end
        return r;
    endfunction

    function automatic logic expected_err(input logic [NW*W-1:0] v);
        logic bad;
        bad = 1'b0;
`ifdef MERGE_ORDER_CHECK_EN
        for (int r = 0; r < NW / RL; r++)
            for (int i = 0; i < RL - 1; i++)
                if (v[(NW-1-(r*RL+i))*W +: W] > v[(NW-1-(r*RL+i+1))*W +: W]) bad = 1'b1;
`endif
        return bad;
    endfunction

    // Starts one merge and follows it to completion, checking timing, busy, result and run_err.
    task automatic run_merge(input string tag, input logic [NW*W-1:0] din, input logic [NW*W-1:0] exp);
        int done_cyc;
        bit busy_ok;
        logic [NW*W-1:0] got;
        logic err_at_done;
        done_cyc = -1;
        busy_ok = 1'b1;
        got = '0;
        err_at_done = 1'b0;
        @(negedge clock);
        start = 1'b1;
        runs_in = din;
        @(posedge clock);
        #1;
        start = 1'b0;
        runs_in = {$urandom, $urandom};
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(negedge clock);
            if (busy !== ((c >= 1 && c <= 9) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                got = runs_out;
                err_at_done = run_err;
            end
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd10);
        check({tag, " busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, " runs_out"}, got, exp);
        check({tag, " run_err"}, 64'(err_at_done), 64'(expected_err(din)));
        @(negedge clock);
        check({tag, " done_single"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[5];
    int extra_done;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        runs_in = '0;
        vecs[0] = '{64'h03070109_05050204, 64'h01030709_02040505};
        vecs[1] = '{64'h01020809_0A0B0001, 64'h01020809_00010A0B};
        vecs[2] = '{64'h05FF05FF_00000000, 64'h0505FFFF_00000000};
        vecs[3] = '{64'hFFFF0000_10201525, 64'h0000FFFF_10152025};
        vecs[4] = '{64'h07030102_03040506, 64'h01020703_03040506};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset runs_out", runs_out, 64'd0);
        check("reset run_err", 64'(run_err), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_merge($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
        end

        // Start re-pulsed at cycles 3 and 9 must be ignored.
        @(negedge clock);
        start = 1'b1;
        runs_in = vecs[0].din;
        @(posedge clock);
        #1;
        start = 1'b0;
        runs_in = vecs[1].din;
        extra_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            start = (c == 3 || c == 9) ? 1'b1 : 1'b0;
            if (c < 10 && done === 1'b1) extra_done++;
            if (c == 10) begin
                check("repulse done_at_10", 64'(done), 64'd1);
                check("repulse runs_out", runs_out, vecs[0].exp);
            end
        end
        start = 1'b0;
        check("repulse early_done", 64'(extra_done), 64'd0);
        run_merge("after_repulse", vecs[1].din, vecs[1].exp);

        // Reset during MERGE aborts the operation.
        @(negedge clock);
        start = 1'b1;
        runs_in = vecs[3].din;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy", 64'(busy), 64'd0);
        check("abort runs_out", runs_out, 64'd0);
        check("abort done", 64'(done), 64'd0);
        reset = 1'b0;
        extra_done = 0;
        repeat (10) begin
            @(negedge clock);
            if (done === 1'b1) extra_done++;
        end
        check("abort no_done", 64'(extra_done), 64'd0);
        run_merge("after_abort", vecs[0].din, vecs[0].exp);

        // Random runs: even iterations use ascending runs, odd ones raw data.
        for (int i = 0; i < 20; i++) begin
            logic [NW*W-1:0] d;
            logic [W-1:0] x, y;
            d = {$urandom, $urandom};
            if (i % 2 == 0) begin
                for (int p = 0; p < NW / RL; p++) begin
                    x = d[(NW-1-2*p)*W +: W];
                    y = d[(NW-2-2*p)*W +: W];
                    if (x > y) begin
                        d[(NW-1-2*p)*W +: W] = y;
                        d[(NW-2-2*p)*W +: W] = x;
                    end
                end
            end
            run_merge($sformatf("rand%0d", i), d, merge_model(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
